// File: rtl/onecold_scan_dec_pkg.sv
// Shared types for the one-cold scan decoder.
// FSM state encoding and mode constants.
package onecold_scan_dec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/onecold_scan_dec_dec.sv
// Combinational SEL_W-to-2**SEL_W active-low decoder.
// Ports: sel_i index, en_n_i active-low enable, out_n_o one-cold lines.
module onecold_dec #(
  parameter int SEL_W = 4,
  parameter int N     = 1 << SEL_W
) (
  input  logic [SEL_W-1:0] sel_i,
  input  logic             en_n_i,
  output logic [N-1:0]     out_n_o
);

  always_comb begin
    out_n_o = '1;
    for (int i = 0; i < N; i++) begin
      out_n_o[i] = en_n_i | (sel_i != SEL_W'(i));
    end
  end

endmodule

// File: rtl/onecold_scan_dec.sv
// One-cold line driver: DIRECT (load-selected) or SCAN (rotating) mode,
// with a blank cycle between every line change (break-before-make).
// Ports: clk, rst_n, en_n, mode, load, sel_in, last, dwell in;
//        out (active-low lines), cur_sel, active, wrap out.
module onecold_scan_dec
  import onecold_scan_dec_pkg::*;
#(
  parameter int SEL_W   = 4,
  parameter int DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_n,
  input  logic                  mode,
  input  logic                  load,
  input  logic [SEL_W-1:0]      sel_in,
  input  logic [SEL_W-1:0]      last,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [(1<<SEL_W)-1:0] out,
  output logic [SEL_W-1:0]      cur_sel,
  output logic                  active,
  output logic                  wrap
);

  localparam int N = 1 << SEL_W;

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic                 mode_q;
  logic                 wrap_q, wrap_d;
  logic                 active_q;
  logic [N-1:0]         out_q;
  logic [N-1:0]         dec_out;
  logic                 dec_en_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_DIRECT;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode;
    end
  end

  // mode_q tracks the previous cycle's mode so any toggle drops to IDLE.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    if (en_n || (mode != mode_q)) begin
      state_d = IDLE;
    end else if (mode == MODE_DIRECT) begin
      if (load) begin
        state_d = BLANK;
        sel_d   = sel_in;
      end else if (state_q == BLANK) begin
        state_d = DRIVE;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = BLANK;
          sel_d   = '0;
        end
        BLANK: begin
          state_d = DRIVE;
          cnt_d   = dwell;
        end
        DRIVE: begin
          if (cnt_q == '0) begin
            state_d = BLANK;
            // >= so a last lowered below sel_q still wraps.
            if (sel_q >= last) begin
              sel_d  = '0;
              wrap_d = 1'b1;
            end else begin
              sel_d = sel_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Decode from next state so registered out lines up with state_q.
  always_comb begin
    dec_en_n = (state_d != DRIVE);
  end

  onecold_dec #(
    .SEL_W (SEL_W),
    .N     (N)
  ) u_dec (
    .sel_i   (sel_d),
    .en_n_i  (dec_en_n),
    .out_n_o (dec_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= '1;
      active_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      out_q    <= dec_out;
      active_q <= ~dec_en_n;
      wrap_q   <= wrap_d;
    end
  end

  assign out     = out_q;
  assign active  = active_q;
  assign wrap    = wrap_q;
  assign cur_sel = sel_q;

endmodule
